hdlc_tx_framer: RTL and testbench

//  Bit-level HDLC transmit framer: the Tx end of the serial line that the Rx

---
 rtl/hdlc_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - HDLC bit-level transmit framer: flags, zero stuffing, abort, idle ones
module hdlc_tx_framer #(
  parameter int STUFF_RUN  = 5,
  parameter int ABORT_ONES = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEN,
  input  logic       Tx_ValidFrame,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  typedef enum logic [2:0] {IDLE, OPEN, DATA, CLOSE, ABORT} txState_t;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [2:0] STUFF_AT  = 3'(STUFF_RUN);
  localparam logic [3:0] ABORT_END = 4'(ABORT_ONES + 1);

  txState_t   state, stateNext;
  logic [3:0] bitCnt, bitCntNext;
  logic [2:0] onesCnt, onesCntNext;
  logic [7:0] shreg, shregNext;
  logic       abortPend, abortPendNext;
  logic       txNext, rdBuffNext, doneNext, abortedNext;
  logic       inFrame, endOfByte;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      bitCnt          <= 4'd0;
      onesCnt         <= 3'd0;
      shreg           <= 8'h00;
      abortPend       <= 1'b0;
      Tx              <= 1'b1;
      Tx_RdBuff       <= 1'b0;
      Tx_Busy         <= 1'b0;
      Tx_Done         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
    end else begin
      state           <= stateNext;
      bitCnt          <= bitCntNext;
      onesCnt         <= onesCntNext;
      shreg           <= shregNext;
      abortPend       <= abortPendNext;
      Tx              <= txNext;
      Tx_RdBuff       <= rdBuffNext;
      Tx_Busy         <= (stateNext != IDLE);
      Tx_Done         <= doneNext;
      Tx_AbortedTrans <= abortedNext;
    end
  end

  // Each segment decides its successor on the edge that emits its last bit,
  // so the next segment's first bit follows with no gap on the line.
  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    onesCntNext   = onesCnt;
    shregNext     = shreg;
    abortPendNext = abortPend;
    txNext        = Tx;
    rdBuffNext    = 1'b0;
    doneNext      = 1'b0;
    abortedNext   = 1'b0;
    endOfByte     = 1'b0;
    inFrame       = (state == OPEN) || (state == DATA) || (state == CLOSE);

    if (state == IDLE) begin
      abortPendNext = 1'b0;
    end else if (inFrame && Tx_AbortFrame) begin
      abortPendNext = 1'b1;
    end

    if (TxEN) begin
      if (inFrame && abortPend) begin
        stateNext     = ABORT;
        bitCntNext    = 4'd1;
        txNext        = 1'b0;
        abortPendNext = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            txNext = 1'b1;
            if (Tx_ValidFrame) begin
              stateNext  = OPEN;
              bitCntNext = 4'd0;
            end
          end
          OPEN: begin
            txNext     = FLAG[bitCnt[2:0]];
            bitCntNext = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              bitCntNext = 4'd0;
              if (Tx_DataAvail) begin
                shregNext   = Tx_Data;
                rdBuffNext  = 1'b1;
                onesCntNext = 3'd0;
                stateNext   = DATA;
              end else if (!Tx_ValidFrame) begin
                stateNext = IDLE;
              end
            end
          end
          DATA: begin
            if (onesCnt == STUFF_AT) begin
              txNext      = 1'b0;
              onesCntNext = 3'd0;
              endOfByte   = (bitCnt == 4'd8);
            end else begin
              txNext      = shreg[0];
              shregNext   = {1'b0, shreg[7:1]};
              bitCntNext  = bitCnt + 4'd1;
              onesCntNext = shreg[0] ? onesCnt + 3'd1 : 3'd0;
              endOfByte   = (bitCnt == 4'd7) && (onesCntNext != STUFF_AT);
            end
            if (endOfByte) begin
              bitCntNext = 4'd0;
              if (Tx_DataAvail) begin
                shregNext  = Tx_Data;
                rdBuffNext = 1'b1;
              end else if (!Tx_ValidFrame) begin
                stateNext = CLOSE;
              end else begin
                stateNext = ABORT;
              end
            end
          end
          CLOSE: begin
            if (bitCnt == 4'd8) begin
              txNext     = 1'b1;
              doneNext   = 1'b1;
              bitCntNext = 4'd0;
              stateNext  = IDLE;
            end else begin
              txNext     = FLAG[bitCnt[2:0]];
              bitCntNext = bitCnt + 4'd1;
            end
          end
          ABORT: begin
            if (bitCnt == ABORT_END) begin
              txNext      = 1'b1;
              abortedNext = 1'b1;
              bitCntNext  = 4'd0;
              stateNext   = IDLE;
            end else begin
              txNext     = (bitCnt != 4'd0);
              bitCntNext = bitCnt + 4'd1;
            end
          end
          default: begin
            stateNext = IDLE;
            txNext    = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - directed bench for hdlc_tx_framer against a per-bit frame model
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       TxEN = 1'b0;
  logic       Tx_ValidFrame = 1'b0;
  logic       Tx_DataAvail = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx_RdBuff, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans;

  hdlc_tx_framer dut (
    .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_DataAvail(Tx_DataAvail), .Tx_Data(Tx_Data), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_RdBuff(Tx_RdBuff), .Tx(Tx), .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {logic tx; logic rd; logic done; logic abt; logic busy;} expT;

  localparam expT IDLE_E = 5'b10000;

  expT        expQ[$];
  logic       gotTx[$];
  logic [7:0] bq[$];
  logic [0:7] flagSeq = 8'b01111110;
  expT        lastE = IDLE_E;
  int         tests = 0;
  int         fails = 0;
  logic       chkOn = 1'b0;
  logic       enAtEdge = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void pushE(logic tx, logic rd, logic done, logic abt, logic busy);
    expQ.push_back({tx, rd, done, abt, busy});
  endfunction

  // Frame expectation: one entry per bit strobe, starting with the strobe that sees ValidFrame.
  function automatic void buildFrame(input logic [7:0] bytes[$], input int mode, input int abortAt);
    int   ones;
    logic b;
    ones = 0;
    expQ.delete();
    pushE(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pushE(flagSeq[i], 1'b0, 1'b0, 1'b0, 1'b1);
    if (bytes.size() > 0) expQ[expQ.size()-1].rd = 1'b1;
    for (int k = 0; k < bytes.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        b = bytes[k][i];
        pushE(b, 1'b0, 1'b0, 1'b0, 1'b1);
        ones = b ? ones + 1 : 0;
        if (ones == 5) begin
          pushE(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          ones = 0;
        end
      end
      if (k + 1 < bytes.size()) expQ[expQ.size()-1].rd = 1'b1;
    end
    if (mode == 2) while (expQ.size() > abortAt) void'(expQ.pop_back());
    if (mode == 0) begin
      for (int i = 0; i < 8; i++) pushE(flagSeq[i], 1'b0, 1'b0, 1'b0, 1'b1);
      pushE(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      pushE(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) pushE(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      pushE(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endfunction

  always @(posedge Clk) enAtEdge = TxEN;

  always @(negedge Clk) begin
    expT e;
    if (chkOn) begin
      if (enAtEdge) begin
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          gotTx.push_back(Tx);
        end else begin
          e = IDLE_E;
        end
        check("tx", Tx, e.tx);
        check("rdbuff", Tx_RdBuff, e.rd);
        check("done", Tx_Done, e.done);
        check("aborted", Tx_AbortedTrans, e.abt);
        check("busy", Tx_Busy, e.busy);
        lastE = e;
      end else begin
        check("tx_hold", Tx, lastE.tx);
        check("busy_hold", Tx_Busy, lastE.busy);
        check("pulse_hold", {Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 3'b000);
      end
    end
  end

  function automatic void setBytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    bq.delete();
    if (n > 0) bq.push_back(b0);
    if (n > 1) bq.push_back(b1);
  endfunction

  // mode 0: close normally, 1: underrun, 2: AbortFrame so that the abort starts at entry abortAt
  task automatic runFrame(input string name, input int mode, input int abortAt, input int period,
                          input logic [63:0] lit, input int litLen);
    int         len, edges, cyc, idx;
    logic [63:0] v;
    @(negedge Clk); #1;
    buildFrame(bq, mode, abortAt);
    len = expQ.size();
    if (litLen > 0) begin
      v = '0;
      for (int i = 1; i <= litLen; i++) v = {v[62:0], expQ[i].tx};
      check({name, "_model"}, v, lit);
    end
    gotTx.delete();
    edges = 0; cyc = 0; idx = 0;
    Tx_Data = (bq.size() > 0) ? bq[0] : 8'h00;
    Tx_DataAvail = (bq.size() > 0);
    Tx_ValidFrame = 1'b1;
    TxEN = 1'b1;
    while (edges < len && cyc < 4000) begin
      @(negedge Clk); #1;
      cyc++;
      if (enAtEdge) edges++;
      TxEN = (cyc % period == 0);
      Tx_AbortFrame = (mode == 2) && (edges == abortAt - 1);
      if (Tx_RdBuff) begin
        idx++;
        if (idx < bq.size()) Tx_Data = bq[idx];
        else begin
          Tx_DataAvail = 1'b0;
          if (mode == 0) Tx_ValidFrame = 1'b0;
        end
      end
      if (Tx_AbortedTrans) begin
        Tx_ValidFrame = 1'b0;
        Tx_DataAvail = 1'b0;
      end
    end
    check({name, "_finished"}, edges >= len, 1'b1);
    Tx_ValidFrame = 1'b0;
    Tx_DataAvail = 1'b0;
    Tx_AbortFrame = 1'b0;
    TxEN = 1'b1;
    @(negedge Clk); #1;
    if (litLen > 0) begin
      v = '0;
      for (int i = 1; i <= litLen; i++) v = {v[62:0], (i < gotTx.size()) ? gotTx[i] : 1'bx};
      check({name, "_dut"}, v, lit);
    end
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    check("rst_tx", Tx, 1'b1);
    check("rst_busy", Tx_Busy, 1'b0);
    check("rst_rdbuff", Tx_RdBuff, 1'b0);
    check("rst_done", Tx_Done, 1'b0);
    check("rst_aborted", Tx_AbortedTrans, 1'b0);
    Rst = 1'b1;
    TxEN = 1'b1;
    lastE = IDLE_E;
    chkOn = 1'b1;
    repeat (32) @(negedge Clk);

    setBytes(2, 8'h55, 8'hA3);
    runFrame("frame_55_a3", 0, 0, 1, 64'b01111110_10101010_11000101_01111110, 32);
    setBytes(2, 8'hFF, 8'h01);
    runFrame("stuff_ff_01", 0, 0, 1, 64'b01111110_111110111_10000000_01111110, 33);
    setBytes(1, 8'hF8, 8'h00);
    runFrame("stuff_before_close", 0, 0, 1, 64'b01111110_00011111_0_01111110, 25);
    setBytes(1, 8'h7E, 8'h00);
    runFrame("abort_midbyte", 2, 12, 1, 64'b01111110_011_01111111, 19);
    setBytes(2, 8'h11, 8'h22);
    runFrame("abort_at_eob", 2, 16, 1, 64'b01111110_1000100_01111111, 23);
    setBytes(1, 8'h0F, 8'h00);
    runFrame("underrun", 1, 0, 1, 64'b01111110_11110000_01111111, 24);
    setBytes(2, 8'h55, 8'hA3);
    runFrame("txen_1in4", 0, 0, 4, 64'b01111110_10101010_11000101_01111110, 32);

    chkOn = 1'b0;
    @(negedge Clk); #1;
    Tx_Data = 8'h55;
    Tx_DataAvail = 1'b1;
    Tx_ValidFrame = 1'b1;
    TxEN = 1'b1;
    repeat (12) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("midrst_tx", Tx, 1'b1);
    check("midrst_busy", Tx_Busy, 1'b0);
    check("midrst_pulses", {Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 3'b000);
    Tx_ValidFrame = 1'b0;
    Tx_DataAvail = 1'b0;
    @(negedge Clk); #1;
    Rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk); #1;
      check("postrst_idle", {Tx, Tx_Busy, Tx_RdBuff, Tx_Done, Tx_AbortedTrans}, 5'b10000);
    end
    lastE = IDLE_E;
    chkOn = 1'b1;
    repeat (8) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
